// File: rtl/seq_div_16_8.sv
// seq_div_16_8 -- sequential restoring divider, unsigned DW / VW bits,
// one quotient bit per clock.
//
// Parameters:
//   DW  dividend / quotient width (default 16)
//   VW  divisor / remainder width (default 8), VW <= DW
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, accepted on an edge where ready=1
//   dividend   unsigned dividend, sampled on the accept edge
//   divisor    unsigned divisor, sampled on the accept edge
//   ready      high while idle
//   busy       high while running or finishing
//   valid      one-cycle result strobe
//   quotient   result quotient, held until the next result
//   remainder  result remainder, held until the next result
//   div0       divisor was zero for the current result
// Build option:
//   DIV_FAST_ZERO_EN  a zero divisor skips the iterations and finishes
//                     directly; results are identical, only latency shrinks.

module seq_div_16_8 #(
  parameter int unsigned DW = 16,
  parameter int unsigned VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          valid,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div0
);

  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [VW-1:0] r;       // partial remainder
  logic [DW-1:0] q;       // dividend shifting out, quotient shifting in
  logic [VW-1:0] dvs;     // latched divisor
  logic          dz;      // latched divisor==0
  logic [VW:0]   r_sh;
  logic [VW-1:0] r_diff;
  logic          ge;

  // The partial remainder is VW+1 bits wide only transiently: after each
  // restore/subtract it is below the divisor, so only VW bits are stored
  // and the extra bit exists in the shifted value used for the compare.
  always_comb begin
    r_sh   = {r, q[DW-1]};
    ge     = (r_sh >= {1'b0, dvs});
    r_diff = r_sh[VW-1:0] - dvs;
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef DIV_FAST_ZERO_EN
          state_nx = (divisor == '0) ? DONE : RUN;
`else
          state_nx = RUN;
`endif
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      dz        <= 1'b0;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div0      <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvs <= divisor;
            dz  <= (divisor == '0);
            cnt <= CW'(DW - 1);
`ifdef DIV_FAST_ZERO_EN
            // Preload exactly what the full iteration would produce.
            if (divisor == '0) begin
              q <= '1;
              r <= dividend[VW-1:0];
            end else begin
              q <= dividend;
              r <= '0;
            end
`else
            q <= dividend;
            r <= '0;
`endif
          end
        end
        RUN: begin
          r <= ge ? r_diff : r_sh[VW-1:0];
          q <= {q[DW-2:0], ge};
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          valid     <= 1'b1;
          quotient  <= q;
          remainder <= r;
          div0      <= dz;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_16_8.sv
// tb_seq_div_16_8 -- self-checking bench for seq_div_16_8 (DW=16, VW=8).
// Results are compared with plain integer division; timing is measured in
// clock edges from the accept edge.

module tb_seq_div_16_8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div0;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned last_acc = 0;
  int unsigned prev_acc = 0;

`ifdef DIV_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  seq_div_16_8 #(.DW(16), .VW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .valid     (valid),
    .quotient  (quotient),
    .remainder (remainder),
    .div0      (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_q(input int unsigned a, input int unsigned b);
    return (b == 0) ? 32'hFFFF : a / b;
  endfunction

  function automatic int unsigned ref_r(input int unsigned a, input int unsigned b);
    return (b == 0) ? (a % 256) : a % b;
  endfunction

  // One division. Entered and left just after a falling edge.
  // chain_in: the previous call already drove start with these operands.
  // chain_out: leave start high with (na, nb) during the valid cycle.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input bit spam,
                       input bit chain_in, input bit chain_out,
                       input logic [15:0] na, input logic [7:0] nb);
    int unsigned lat;
    int unsigned busy_bad;
    int unsigned exp_lat;
    bit          got;
    logic [15:0] qv;
    logic [7:0]  rv;
    if (!chain_in) begin
      lat = 0;
      while (!ready && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      check("ready_wait", 32'(ready), 32'd1);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
    end
    @(posedge clk);
    #1;
    prev_acc = last_acc;
    last_acc = cyc;
    start = spam;
    if (spam) begin
      dividend = 16'($urandom);
      divisor  = 8'($urandom);
    end
    lat = 0;
    busy_bad = 0;
    got = 1'b0;
    while (lat < 40 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (valid) begin
        got = 1'b1;
      end else begin
        if (!busy || ready) busy_bad++;
        if (spam) begin
          start    = 1'b1;
          dividend = 16'($urandom);
          divisor  = 8'($urandom);
        end
      end
    end
    exp_lat = (FAST && b == 0) ? 1 : 17;
    check("latency", lat, exp_lat);
    check("busy_run", busy_bad, 0);
    check("quotient", 32'(quotient), ref_q(a, b));
    check("remainder", 32'(remainder), ref_r(a, b));
    check("div0", 32'(div0), 32'(b == 0));
    if (b != 0) check("recompose", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
    if (chain_out) begin
      dividend = na;
      divisor  = nb;
      start    = 1'b1;
    end else begin
      start = 1'b0;
      qv = quotient;
      rv = remainder;
      @(negedge clk);
      check("valid_width", 32'(valid), 32'd0);
      check("hold", {8'd0, rv, qv}, {8'd0, remainder, quotient});
    end
  endtask

  initial begin
    int unsigned vcount;
    logic [15:0] ra;
    logic [7:0]  rb;

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_outs", {7'd0, div0, remainder, quotient}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(16'd1000, 8'd7, 1'b0, 1'b0, 1'b0, '0, '0);
    do_op(16'hFFFF, 8'hFF, 1'b0, 1'b0, 1'b1, 16'd5, 8'd9);
    do_op(16'd5, 8'd9, 1'b0, 1'b1, 1'b0, '0, '0);
    check("spacing", last_acc - prev_acc, 32'd18);
    do_op(16'h1234, 8'd0, 1'b0, 1'b0, 1'b0, '0, '0);

    // start held with fresh operands throughout the run
    do_op(16'd50000, 8'd13, 1'b1, 1'b0, 1'b1, 16'd777, 8'd10);
    do_op(16'd777, 8'd10, 1'b0, 1'b1, 1'b0, '0, '0);
    check("spacing_spam", last_acc - prev_acc, 32'd18);

    // reset during the 8th RUN cycle
    dividend = 16'hBEEF;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_outs", {7'd0, div0, remainder, quotient}, 32'd0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    check("mid_rst_no_valid", vcount, 0);

    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 8'd0;
        1: rb = 8'd1;
        2: rb = 8'hFF;
        3: ra = 16'($urandom_range(0, 300));
        default: ;
      endcase
      do_op(ra, rb, 1'b0, 1'b0, 1'b0, '0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
